// File: rtl/sprite_ram_loader_if.sv
// Token stream and sprite RAM write port of the sprite loader.
// The loader uses the slave view; the token source / RAM side uses master.
interface sprite_ram_loader_if #(
  parameter int unsigned PIXEL_W = 24,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned RUN_W   = 8
);
  logic               tok_valid;
  logic               tok_ready;
  logic [RUN_W-1:0]   tok_run;
  logic [PIXEL_W-1:0] tok_color;
  logic [ADDR_W-1:0]  write_address;
  logic [PIXEL_W-1:0] data_in;
  logic               we;

  modport master (
    output tok_valid, tok_run, tok_color,
    input  tok_ready, write_address, data_in, we
  );

  modport slave (
    input  tok_valid, tok_run, tok_color,
    output tok_ready, write_address, data_in, we
  );
endinterface

// File: rtl/sprite_ram_loader.sv
// Expands a run-length pixel token stream into row-major single-pixel writes
// filling one IMAGE_WIDTH x IMAGE_HEIGHT sprite per start; reports done or err.
module sprite_ram_loader #(
  parameter int unsigned IMAGE_WIDTH  = 50,
  parameter int unsigned IMAGE_HEIGHT = 44,
  parameter int unsigned PIXEL_W      = 24,
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned RUN_W        = 8,
  parameter int unsigned BASE_ADDR    = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic                abort,
  sprite_ram_loader_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [9:0]          row,
  output logic [9:0]          col
);

  localparam int unsigned       TOTAL    = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_POS = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [9:0]        LAST_COL = 10'(IMAGE_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_EXPAND,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pos, pos_n;
  logic [RUN_W-1:0]   remaining, remaining_n;
  logic [PIXEL_W-1:0] color, color_n;
  logic [9:0]         row_n, col_n;
  logic               err_n;
  logic [ADDR_W-1:0]  waddr_q, waddr_n;
  logic [PIXEL_W-1:0] wdata_q, wdata_n;
  logic               tok_ready_q;
  logic               we_q;

  assign bus.tok_ready     = tok_ready_q;
  assign bus.we            = we_q;
  assign bus.write_address = waddr_q;
  assign bus.data_in       = wdata_q;

  // Next-state and datapath update; abort overrides every state.
  always_comb begin
    state_n     = state;
    pos_n       = pos;
    remaining_n = remaining;
    color_n     = color;
    row_n       = row;
    col_n       = col;
    err_n       = err;

    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_n = S_ACCEPT;
            pos_n   = '0;
            row_n   = '0;
            col_n   = '0;
            err_n   = 1'b0;
          end
        end

        S_ACCEPT: begin
          if (bus.tok_valid && tok_ready_q) begin
            remaining_n = bus.tok_run;
            color_n     = bus.tok_color;
            if (bus.tok_run == '0) begin
              state_n = S_ERROR;
              err_n   = 1'b1;
            end else begin
              state_n = S_EXPAND;
            end
          end
        end

        S_EXPAND: begin
          pos_n       = pos + ADDR_W'(1);
          remaining_n = remaining - RUN_W'(1);
          if (col == LAST_COL) begin
            col_n = '0;
            row_n = row + 10'd1;
          end else begin
            col_n = col + 10'd1;
          end
          // Last pixel slot of the sprite: exact fit finishes, anything more overflows.
          if (pos == LAST_POS) begin
            if (remaining == RUN_W'(1)) begin
              state_n = S_DONE;
            end else begin
              state_n = S_ERROR;
              err_n   = 1'b1;
            end
          end else if (remaining == RUN_W'(1)) begin
            state_n = S_ACCEPT;
          end
        end

        S_DONE:  state_n = S_IDLE;
        S_ERROR: state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end

    // Write port only moves when a write is scheduled, so it never leaves the sprite.
    waddr_n = waddr_q;
    wdata_n = wdata_q;
    if (state_n == S_EXPAND) begin
      waddr_n = BASE + pos_n;
      wdata_n = color_n;
    end
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= S_IDLE;
      pos         <= '0;
      remaining   <= '0;
      color       <= '0;
      row         <= '0;
      col         <= '0;
      err         <= 1'b0;
      tok_ready_q <= 1'b0;
      we_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      waddr_q     <= BASE;
      wdata_q     <= '0;
    end else begin
      state       <= state_n;
      pos         <= pos_n;
      remaining   <= remaining_n;
      color       <= color_n;
      row         <= row_n;
      col         <= col_n;
      err         <= err_n;
      tok_ready_q <= (state_n == S_ACCEPT);
      we_q        <= (state_n == S_EXPAND);
      busy        <= (state_n != S_IDLE);
      done        <= (state_n == S_DONE);
      waddr_q     <= waddr_n;
      wdata_q     <= wdata_n;
    end
  end

endmodule

// File: doc/sprite_ram_loader.md
Name: sprite_ram_loader

Overview:
- Writer side of the sprite RAM read by the enemy sprite renderers.
- Accepts a run-length-encoded pixel token stream over a valid/ready handshake. Expands each token into consecutive single-pixel writes on the RAM's write port (write_address / data_in / we), in row-major order.
- Loads one full IMAGE_WIDTH x IMAGE_HEIGHT sprite per start. Reports done or error.

Parameters:
- IMAGE_WIDTH, 50: sprite width in pixels.
- IMAGE_HEIGHT, 44: sprite height in pixels.
- PIXEL_W, 24: pixel width, packed {R[7:0],G[7:0],B[7:0]}.
- ADDR_W, 19: RAM address width.
- RUN_W, 8: run-length field width.
- BASE_ADDR, 0: RAM address of pixel (row 0, col 0).

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin loading a sprite.
- abort  in  1  cancel the load in progress.
- tok_valid  in  1  token present.
- tok_ready  out  1  loader can accept a token.
- tok_run  in  RUN_W  pixel count of the token, 1..2^RUN_W-1.
- tok_color  in  PIXEL_W  pixel value for the whole run.
- write_address  out  ADDR_W  RAM write address.
- data_in  out  PIXEL_W  RAM write data.
- we  out  1  RAM write enable.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse: full sprite written.
- err  out  1  sticky error flag.
- row  out  10  row of the next pixel to write.
- col  out  10  column of the next pixel to write.

Behaviour:
- Reset (async, Reset=0) values:
  - state=IDLE; tok_ready=0, we=0, busy=0, done=0, err=0.
  - write_address=BASE_ADDR, data_in=0, row=0, col=0.
  - Internal pos=0, remaining=0.
- Outputs are decoded from registers only; no combinational path from any input to any output.
- TOTAL = IMAGE_WIDTH*IMAGE_HEIGHT (2200 by default). TOTAL must fit in ADDR_W bits.
- IDLE:
  - tok_ready=0.
  - start=1 -> ACCEPT; clear pos, row, col and err.
- ACCEPT:
  - tok_ready=1, we=0.
  - On tok_valid&tok_ready: latch remaining=tok_run and color=tok_color.
  - tok_run==0 -> ERROR; otherwise -> EXPAND.
- EXPAND:
  - tok_ready=0, we=1, write_address=BASE_ADDR+pos, data_in=color. One pixel per cycle.
  - Each cycle: pos++ and remaining--; col++, with col wrapping from IMAGE_WIDTH-1 to 0 while row++.
  - Exit, evaluated on the write cycle, in priority order:
    1. pos==TOTAL-1 and remaining==1 -> DONE.
    2. pos==TOTAL-1 and remaining>1 -> ERROR (overflow; excess pixels discarded, never written).
    3. remaining==1 -> ACCEPT.
    4. Otherwise stay in EXPAND.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- ERROR: err=1 (sticky until the next accepted start or Reset), then -> IDLE next cycle. No done pulse.
- Throughput: a token of run N takes 1 ACCEPT cycle + N write cycles.
- Latency: first we at cycle start+2 when tok_valid is already high.
- Simultaneous events:
  - abort has priority over everything: in any state it goes to IDLE next cycle, with we=0, tok_ready=0, no done, err unchanged.
  - start is ignored while busy=1.
  - start and abort in the same IDLE cycle -> stay in IDLE.
- Reset mid-EXPAND: we drops to 0 immediately (asynchronous), and all registers take their reset values.
- write_address never exceeds BASE_ADDR+TOTAL-1.

Test Plan:
1. Reset, then start. Send 11 tokens {run=200, color=24'hFF0000} with tok_valid held high -> 2200 writes at addresses 0..2199, all data 24'hFF0000. done pulses once, the cycle after the address-2199 write. err=0, busy=0 afterwards.
2. Row wrap: start, then one token {run=60, color=24'h00FF00} with tok_valid then dropped -> 60 writes at addresses 0..59. Loader ends in ACCEPT with row=1, col=10, tok_ready=1.
3. Overflow: start, then 9 tokens of run=255 (2295 pixels) -> exactly 2200 writes, last at address 2199. err=1, no done, busy=0. A following start clears err.
4. Zero run: start, then token {run=0} -> no writes, err=1, IDLE.
5. Abort and reset mid-run: during a run=100 token, abort at the 30th write -> we=0 next cycle, 30 writes total, no done. Repeat with Reset=0 instead -> we=0 asynchronously, and all outputs at their reset values.
6. Backpressure and busy: tok_valid gaps of 5 cycles between tokens -> tok_ready stays high and no writes occur during gaps. A start pulse while busy -> no restart, and pos/address sequence is unchanged.
